debug_trace_buffer: RTL and testbench

Synthesizable, parametrised successor to the file-logging CPU bench. It captures per-instruction snapshots (sequence stamp, PC and NUM_CH debug words, e.g. register-file probes) into an on-chip buffer, so traces survive on the board without a simulator. A PC-match trigger and two capture modes are supported: linear (start at trigger) and circular (pre/post-trigger window). The block sits beside the single-cycle/pipelined CPU and taps the debug_pc / debug_rf_data style probes. Readout is random-access through a registered port.

---
 rtl/cpu_dbg_pkg.sv | 21 ++
 rtl/trace_ram.sv | 25 ++
 rtl/debug_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_debug_trace_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the on-chip CPU debug trace buffer: FSM states,
// readout channel codes and capture mode codes.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int CH_STAMP = 0;
   localparam int CH_PC    = 1;
   localparam int CH_BASE  = 2;

   localparam logic MODE_LINEAR   = 1'b0;
   localparam logic MODE_CIRCULAR = 1'b1;

   localparam int STAMP_W = 32;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// on the array so it maps onto block RAM.
module trace_ram #(
   parameter  int WIDTH  = 64,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_q
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
   end

endmodule

// File: rtl/debug_trace_buffer.sv
// Captures per-instruction {stamp, PC, debug channels} snapshots into a trace
// RAM with PC-match triggering in linear or circular (pre/post window) mode.
module debug_trace_buffer
   import cpu_dbg_pkg::*;
#(
   parameter  int NUM_CH = 1,
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CH_W   = ($clog2(NUM_CH + 2) < 1) ? 1 : $clog2(NUM_CH + 2)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arm,
   input  logic                     abort,
   input  logic                     mode,
   input  logic                     trig_any,
   input  logic [DATA_W-1:0]        trig_pc,
   input  logic [ADDR_W-1:0]        post_len,
   input  logic                     smp_valid,
   input  logic [DATA_W-1:0]        smp_pc,
   input  logic [NUM_CH*DATA_W-1:0] smp_data,
   input  logic [ADDR_W-1:0]        rd_idx,
   input  logic [CH_W-1:0]          rd_ch,
   output logic [DATA_W-1:0]        rd_data,
   output logic [1:0]               state,
   output logic [ADDR_W:0]          count,
   output logic                     triggered,
   output logic                     done
);

   localparam int ENTRY_W = STAMP_W + DATA_W * (1 + NUM_CH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

   state_t              state_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W-1:0]   remaining_q;
   logic [STAMP_W-1:0]  stamp_q;
   logic                triggered_q;
   logic                mode_q;
   logic                trig_any_q;
   logic [DATA_W-1:0]   trig_pc_q;
   logic [ADDR_W-1:0]   post_len_q;

   logic                trig_hit;
   logic                wr_en;
   logic [ENTRY_W-1:0]  ram_q;
   logic [ADDR_W-1:0]   rd_phys;
   logic                rd_ok_q;
   logic [CH_W-1:0]     rd_ch_q;

   // Arm and abort cycles swallow any coincident sample.
   assign trig_hit = smp_valid && (trig_any_q || (smp_pc == trig_pc_q));
   assign wr_en    = smp_valid && !rst && !abort && !arm &&
                     (((state_q == ST_ARMED) && ((mode_q == MODE_CIRCULAR) || trig_hit)) ||
                      (state_q == ST_CAPTURE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         remaining_q <= '0;
         stamp_q     <= '0;
         triggered_q <= 1'b0;
         mode_q      <= MODE_LINEAR;
         trig_any_q  <= 1'b0;
         trig_pc_q   <= '0;
         post_len_q  <= '0;
      end else if (abort) begin
         state_q <= ST_IDLE;
      end else if (arm) begin
         state_q     <= ST_ARMED;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         remaining_q <= '0;
         stamp_q     <= '0;
         triggered_q <= 1'b0;
         mode_q      <= mode;
         trig_any_q  <= trig_any;
         trig_pc_q   <= trig_pc;
         post_len_q  <= post_len;
      end else if (smp_valid && ((state_q == ST_ARMED) || (state_q == ST_CAPTURE))) begin
         stamp_q <= stamp_q + 1'b1;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (count_q != FULL_CNT) begin
               count_q <= count_q + 1'b1;
            end
         end
         if (state_q == ST_ARMED) begin
            if (trig_hit) begin
               triggered_q <= 1'b1;
               remaining_q <= post_len_q;
               if ((mode_q == MODE_CIRCULAR) && (post_len_q == '0)) begin
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_CAPTURE;
               end
            end
         end else if (mode_q == MODE_LINEAR) begin
            if (count_q == LAST_CNT) begin
               state_q <= ST_DONE;
            end
         end else begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == ADDR_W'(1)) begin
               state_q <= ST_DONE;
            end
         end
      end
   end

   // Logical index 0 is the oldest entry still held in the buffer.
   assign rd_phys = wr_ptr_q - count_q[ADDR_W-1:0] + rd_idx;

   trace_ram #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data ({smp_data, smp_pc, stamp_q}),
      .rd_addr (rd_phys),
      .rd_q    (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ok_q <= 1'b0;
         rd_ch_q <= '0;
      end else begin
         rd_ok_q <= ({1'b0, rd_idx} < count_q) && (rd_ch <= CH_W'(NUM_CH + 1));
         rd_ch_q <= rd_ch;
      end
   end

   // Field select runs on the registered RAM word, keeping one cycle of latency.
   always_comb begin
      rd_data = '0;
      if (rd_ok_q) begin
         if (rd_ch_q == CH_W'(CH_STAMP)) begin
            rd_data = DATA_W'(ram_q[STAMP_W-1:0]);
         end else if (rd_ch_q == CH_W'(CH_PC)) begin
            rd_data = ram_q[STAMP_W +: DATA_W];
         end else begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (rd_ch_q == CH_W'(CH_BASE + k)) begin
                  rd_data = ram_q[STAMP_W + DATA_W * (k + 1) +: DATA_W];
               end
            end
         end
      end
   end

   assign state     = state_q;
   assign count     = count_q;
   assign triggered = triggered_q;
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer (DEPTH 8, one channel): table-driven
// readout checks plus hand-written arm/abort/reset corner sequences.
module tb_debug_trace_buffer;

   localparam int NUM_CH = 1;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int CH_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     arm;
   logic                     abort;
   logic                     mode;
   logic                     trig_any;
   logic [DATA_W-1:0]        trig_pc;
   logic [ADDR_W-1:0]        post_len;
   logic                     smp_valid;
   logic [DATA_W-1:0]        smp_pc;
   logic [NUM_CH*DATA_W-1:0] smp_data;
   logic [ADDR_W-1:0]        rd_idx;
   logic [CH_W-1:0]          rd_ch;
   logic [DATA_W-1:0]        rd_data;
   logic [1:0]               state;
   logic [ADDR_W:0]          count;
   logic                     triggered;
   logic                     done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [ADDR_W-1:0] idx;
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] exp;
   } rd_vec_t;

   rd_vec_t lin_vec[7];
   rd_vec_t circ_vec[6];

   debug_trace_buffer #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .arm       (arm),
      .abort     (abort),
      .mode      (mode),
      .trig_any  (trig_any),
      .trig_pc   (trig_pc),
      .post_len  (post_len),
      .smp_valid (smp_valid),
      .smp_pc    (smp_pc),
      .smp_data  (smp_data),
      .rd_idx    (rd_idx),
      .rd_ch     (rd_ch),
      .rd_data   (rd_data),
      .state     (state),
      .count     (count),
      .triggered (triggered),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic doArm(input logic m, input logic any, input logic [DATA_W-1:0] pc,
                        input logic [ADDR_W-1:0] plen);
      mode      = m;
      trig_any  = any;
      trig_pc   = pc;
      post_len  = plen;
      smp_valid = 1'b0;
      arm       = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic applyStimulus(input int n);
      smp_valid = 1'b1;
      smp_pc    = DATA_W'(4 * n);
      smp_data  = DATA_W'(n + 100);
      tick();
      smp_valid = 1'b0;
   endtask

   task automatic readEntry(input int idx, input int ch, output logic [DATA_W-1:0] val);
      rd_idx = ADDR_W'(idx);
      rd_ch  = CH_W'(ch);
      tick();
      val = rd_data;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [DATA_W-1:0] v;
      int n;

      lin_vec[0] = '{3'd0, 2'd0, 32'd4};
      lin_vec[1] = '{3'd0, 2'd1, 32'h10};
      lin_vec[2] = '{3'd0, 2'd2, 32'd104};
      lin_vec[3] = '{3'd7, 2'd1, 32'h2C};
      lin_vec[4] = '{3'd2, 2'd1, 32'h18};
      lin_vec[5] = '{3'd3, 2'd3, 32'd0};
      lin_vec[6] = '{3'd7, 2'd2, 32'd111};

      circ_vec[0] = '{3'd0, 2'd1, 32'h2C};
      circ_vec[1] = '{3'd5, 2'd1, 32'h40};
      circ_vec[2] = '{3'd7, 2'd1, 32'h48};
      circ_vec[3] = '{3'd5, 2'd0, 32'd16};
      circ_vec[4] = '{3'd5, 2'd2, 32'd116};
      circ_vec[5] = '{3'd0, 2'd0, 32'd11};

      rst = 1'b1; arm = 1'b0; abort = 1'b0; mode = 1'b0; trig_any = 1'b0;
      trig_pc = '0; post_len = '0; smp_valid = 1'b0; smp_pc = '0; smp_data = '0;
      rd_idx = '0; rd_ch = '0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_state", state, 2'd0);
      checkOutput("reset_count", count, 4'd0);
      checkOutput("reset_triggered", triggered, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_rd_data", rd_data, 32'd0);

      // Linear capture starting at pc 0x10
      doArm(1'b0, 1'b0, 32'h10, 3'd0);
      checkOutput("lin_armed", state, 2'd1);
      n = 0;
      while (state != 2'd3 && n < 40) begin
         applyStimulus(n);
         n++;
      end
      checkOutput("lin_samples_to_done", n, 12);
      checkOutput("lin_count", count, 4'd8);
      checkOutput("lin_done", done, 1'b1);
      checkOutput("lin_triggered", triggered, 1'b1);
      for (int i = 0; i < 7; i++) begin
         readEntry(lin_vec[i].idx, lin_vec[i].ch, v);
         checkOutput($sformatf("lin_rd%0d", i), v, lin_vec[i].exp);
      end
      applyStimulus(50);
      checkOutput("lin_done_no_write_count", count, 4'd8);
      readEntry(0, 0, v);
      checkOutput("lin_done_no_write_stamp", v, 32'd4);

      // Circular pre/post window around pc 0x40
      doArm(1'b1, 1'b0, 32'h40, 3'd2);
      n = 0;
      while (state != 2'd3 && n < 40) begin
         applyStimulus(n);
         n++;
      end
      checkOutput("circ_samples_to_done", n, 19);
      checkOutput("circ_count", count, 4'd8);
      for (int i = 0; i < 6; i++) begin
         readEntry(circ_vec[i].idx, circ_vec[i].ch, v);
         checkOutput($sformatf("circ_rd%0d", i), v, circ_vec[i].exp);
      end

      // Circular, trigger on first sample, no post window
      doArm(1'b1, 1'b1, 32'h0, 3'd0);
      applyStimulus(0);
      checkOutput("any_state_done", state, 2'd3);
      checkOutput("any_count", count, 4'd1);
      readEntry(0, 0, v);
      checkOutput("any_idx0_stamp", v, 32'd0);
      readEntry(0, 2, v);
      checkOutput("any_idx0_data", v, 32'd100);
      readEntry(1, 0, v);
      checkOutput("any_idx1_out_of_range", v, 32'd0);

      // Sample coincident with arm is dropped and not stamped
      mode = 1'b1; trig_any = 1'b1; trig_pc = '0; post_len = '0;
      arm = 1'b1; smp_valid = 1'b1; smp_pc = 32'h264; smp_data = 32'd999;
      tick();
      arm = 1'b0; smp_valid = 1'b0;
      checkOutput("armcyc_state", state, 2'd1);
      checkOutput("armcyc_count", count, 4'd0);
      applyStimulus(5);
      readEntry(0, 0, v);
      checkOutput("armcyc_stamp", v, 32'd0);
      readEntry(0, 1, v);
      checkOutput("armcyc_pc", v, 32'h14);

      // Abort in CAPTURE keeps count/triggered and the captured data
      doArm(1'b0, 1'b0, 32'h10, 3'd0);
      for (int i = 0; i < 7; i++) applyStimulus(i);
      checkOutput("abort_pre_state", state, 2'd2);
      abort = 1'b1; smp_valid = 1'b1; smp_pc = 32'h1C; smp_data = 32'd107;
      tick();
      abort = 1'b0; smp_valid = 1'b0;
      checkOutput("abort_state", state, 2'd0);
      checkOutput("abort_count", count, 4'd3);
      checkOutput("abort_triggered", triggered, 1'b1);
      checkOutput("abort_done", done, 1'b0);
      readEntry(2, 1, v);
      checkOutput("abort_idx2_pc", v, 32'h18);
      readEntry(3, 1, v);
      checkOutput("abort_idx3_empty", v, 32'd0);
      applyStimulus(8);
      checkOutput("idle_ignores_count", count, 4'd3);

      // Reset in the middle of a circular ARMED fill
      doArm(1'b1, 1'b0, 32'hFFFC, 3'd1);
      for (int i = 0; i < 3; i++) applyStimulus(i);
      checkOutput("rst_pre_count", count, 4'd3);
      readEntry(1, 2, v);
      checkOutput("rst_pre_data", v, 32'd101);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_state", state, 2'd0);
      checkOutput("rst_count", count, 4'd0);
      checkOutput("rst_triggered", triggered, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_rd_data", rd_data, 32'd0);

      // Trigger never seen in linear mode
      doArm(1'b0, 1'b0, 32'hFFFC, 3'd0);
      for (int i = 0; i < 20; i++) applyStimulus(i);
      checkOutput("nohit_state", state, 2'd1);
      checkOutput("nohit_count", count, 4'd0);
      checkOutput("nohit_triggered", triggered, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
